an_balance_ctrl: RTL and testbench

AN_BALANCE_CTRL -- requirements
Module: an_balance_ctrl

---
 rtl/an_balance_ctrl.sv | 163 ++++++++++++++++
 tb/tb_an_balance_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/an_balance_ctrl.sv
// Balance control for the AN transmitter: debounced UP/DN/CENTER buttons with
// auto-repeat drive a saturating 0..62 balance code.
module an_balance_ctrl #(
  parameter int unsigned C_CK_Fs              = 135_000_000,
  parameter int unsigned C_DEBOUNCE_TICKs     = 10,
  parameter int unsigned C_REPEAT_DELAY_TICKs = 500,
  parameter int unsigned C_REPEAT_RATE_TICKs  = 100,
  parameter int unsigned C_SIM_TICK_CKNs      = 0
) (
  input  logic       CK_i,
  input  logic       XARST_i,
  input  logic       UP_i,
  input  logic       DN_i,
  input  logic       CENTER_i,
  output logic [5:0] BUS_BALANCEs_o,
  output logic       CHG_o,
  output logic       LIMIT_o
);

  localparam int unsigned TickN  = (C_SIM_TICK_CKNs != 0) ? C_SIM_TICK_CKNs : C_CK_Fs / 1000;
  localparam int unsigned TickW  = (TickN > 1) ? $clog2(TickN) : 1;
  localparam int unsigned DebW   = $clog2(C_DEBOUNCE_TICKs + 1);
  localparam int unsigned RptMax = (C_REPEAT_DELAY_TICKs > C_REPEAT_RATE_TICKs) ?
                                   C_REPEAT_DELAY_TICKs : C_REPEAT_RATE_TICKs;
  localparam int unsigned RptW   = (RptMax > 1) ? $clog2(RptMax) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDelay  = 2'd1;
  localparam logic [1:0] StRepeat = 2'd2;

  localparam logic [5:0] BalCenter = 6'd31;
  localparam logic [5:0] BalMax    = 6'd62;

  // Button index: 0 = UP, 1 = DN, 2 = CENTER
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      acc_q, acc_d, acc_dly_q;
  logic [DebW-1:0] deb_cnt_q [3];
  logic [DebW-1:0] deb_cnt_d [3];
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic            tick;
  logic [2:0]      pe;

  logic [1:0]      state_q, state_d;
  logic            dir_q, dir_d;
  logic [RptW-1:0] rpt_ctr_q, rpt_ctr_d;
  logic            step, held, both;

  logic [5:0]      bal_q, bal_d;
  logic            chg_q, limit_q;

  assign tick = (tick_cnt_q == TickW'(TickN - 1));
  assign pe   = acc_q & ~acc_dly_q;

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
  end

  // A level is accepted only after C_DEBOUNCE_TICKs consecutive disagreeing ticks.
  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < 3; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (tick) begin
        if (sync2_q[i] != acc_q[i]) begin
          if (deb_cnt_q[i] == DebW'(C_DEBOUNCE_TICKs - 1)) begin
            acc_d[i]     = ~acc_q[i];
            deb_cnt_d[i] = '0;
          end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
          end
        end else begin
          deb_cnt_d[i] = '0;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    rpt_ctr_d = rpt_ctr_q;
    step      = 1'b0;
    held      = dir_q ? acc_q[0] : acc_q[1];
    both      = acc_q[0] & acc_q[1];
    if (pe[2]) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if ((pe[0] | pe[1]) && (acc_q[0] ^ acc_q[1])) begin
            step      = 1'b1;
            dir_d     = acc_q[0];
            rpt_ctr_d = RptW'(C_REPEAT_DELAY_TICKs - 1);
            state_d   = StDelay;
          end
        end
        StDelay, StRepeat: begin
          // Release or a conflicting press abandons the hold without stepping.
          if (!held || both) begin
            state_d = StIdle;
          end else if (tick) begin
            if (rpt_ctr_q == '0) begin
              step      = 1'b1;
              rpt_ctr_d = RptW'(C_REPEAT_RATE_TICKs - 1);
              state_d   = StRepeat;
            end else begin
              rpt_ctr_d = rpt_ctr_q - RptW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    bal_d = bal_q;
    if (pe[2]) begin
      bal_d = BalCenter;
    end else if (step) begin
      if (dir_d) begin
        bal_d = (bal_q == BalMax) ? bal_q : bal_q + 6'd1;
      end else begin
        bal_d = (bal_q == 6'd0) ? bal_q : bal_q - 6'd1;
      end
    end
  end

  always_ff @(posedge CK_i) begin
    if (!XARST_i) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      acc_q      <= '0;
      acc_dly_q  <= '0;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
      tick_cnt_q <= '0;
      state_q    <= StIdle;
      dir_q      <= 1'b0;
      rpt_ctr_q  <= '0;
      bal_q      <= BalCenter;
      chg_q      <= 1'b0;
      limit_q    <= 1'b0;
    end else begin
      sync1_q    <= {CENTER_i, DN_i, UP_i};
      sync2_q    <= sync1_q;
      acc_q      <= acc_d;
      acc_dly_q  <= acc_q;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      dir_q      <= dir_d;
      rpt_ctr_q  <= rpt_ctr_d;
      bal_q      <= bal_d;
      chg_q      <= (bal_d != bal_q);
      limit_q    <= (bal_d == 6'd0) || (bal_d == BalMax);
    end
  end

  assign BUS_BALANCEs_o = bal_q;
  assign CHG_o          = chg_q;
  assign LIMIT_o        = limit_q;

endmodule

// File: tb/tb_an_balance_ctrl.sv
// Scoreboard bench for an_balance_ctrl: directed button scenarios plus random
// holds, checked against a tick-counting behavioural model.
module tb_an_balance_ctrl;

  localparam int N    = 10;
  localparam int DEB  = 3;
  localparam int DLY  = 5;
  localparam int RATE = 2;

  logic       CK_i     = 1'b0;
  logic       XARST_i  = 1'b0;
  logic       UP_i     = 1'b0;
  logic       DN_i     = 1'b0;
  logic       CENTER_i = 1'b0;
  logic [5:0] BUS_BALANCEs_o;
  logic       CHG_o;
  logic       LIMIT_o;

  an_balance_ctrl #(
    .C_CK_Fs              (135_000_000),
    .C_DEBOUNCE_TICKs     (DEB),
    .C_REPEAT_DELAY_TICKs (DLY),
    .C_REPEAT_RATE_TICKs  (RATE),
    .C_SIM_TICK_CKNs      (N)
  ) dut (
    .CK_i           (CK_i),
    .XARST_i        (XARST_i),
    .UP_i           (UP_i),
    .DN_i           (DN_i),
    .CENTER_i       (CENTER_i),
    .BUS_BALANCEs_o (BUS_BALANCEs_o),
    .CHG_o          (CHG_o),
    .LIMIT_o        (LIMIT_o)
  );

  always #5 CK_i = ~CK_i;

  int n_vec = 0;
  int n_bad = 0;
  int exp_q[$];

  // Model state: button pipelines as plain bit vectors, repeat as elapsed ticks.
  bit [2:0] m_s1, m_s2, m_acc, m_accp;
  int       m_run [3];
  int       m_phase;
  bit       m_active, m_dir;
  int       m_elapsed;
  int       m_bal   = 31;
  bit       m_chg   = 1'b0;
  bit       m_limit = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CK_i) begin : model
    bit       tick;
    bit [2:0] pe;
    bit       up_a, dn_a, step;
    int       nb;
    if (!XARST_i) begin
      m_s1 = '0; m_s2 = '0; m_acc = '0; m_accp = '0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
      m_phase = 0; m_active = 0; m_dir = 0; m_elapsed = 0;
      m_bal = 31; m_chg = 0; m_limit = 0;
    end else begin
      tick = (m_phase == N - 1);
      pe   = m_acc & ~m_accp;
      up_a = m_acc[0];
      dn_a = m_acc[1];
      nb   = m_bal;
      step = 0;
      if (pe[2]) begin
        nb       = 31;
        m_active = 0;
      end else if (!m_active) begin
        if ((pe[0] || pe[1]) && (up_a != dn_a)) begin
          step = 1; m_dir = up_a; m_active = 1; m_elapsed = 0;
        end
      end else if (!(m_dir ? up_a : dn_a) || (up_a && dn_a)) begin
        m_active = 0;
      end else if (tick) begin
        m_elapsed++;
        if (m_elapsed >= DLY && (m_elapsed - DLY) % RATE == 0) step = 1;
      end
      if (step) nb = m_dir ? ((nb < 62) ? nb + 1 : 62) : ((nb > 0) ? nb - 1 : 0);
      m_chg = (nb != m_bal);
      if (m_chg) exp_q.push_back(nb);
      m_bal   = nb;
      m_limit = (nb == 0) || (nb == 62);
      m_accp  = m_acc;
      if (tick) begin
        for (int i = 0; i < 3; i++) begin
          if (m_s2[i] != m_acc[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
              m_acc[i] = ~m_acc[i];
              m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      m_s2    = m_s1;
      m_s1    = {CENTER_i, DN_i, UP_i};
      m_phase = tick ? 0 : m_phase + 1;
    end
  end

  always @(negedge CK_i) begin : monitor
    int e;
    check("balance", int'(BUS_BALANCEs_o), m_bal);
    check("chg", int'(CHG_o), int'(m_chg));
    check("limit", int'(LIMIT_o), int'(m_limit));
    if (CHG_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_chg", int'(BUS_BALANCEs_o), -1);
      end else begin
        e = exp_q.pop_front();
        check("chg_value", int'(BUS_BALANCEs_o), e);
      end
    end
  end

  task automatic run(input int c);
    repeat (c) @(negedge CK_i);
  endtask

  task automatic set_btn(input bit u, input bit d, input bit c);
    UP_i = u; DN_i = d; CENTER_i = c;
  endtask

  task automatic pulse_reset(input int c);
    XARST_i = 1'b0;
    run(c);
    XARST_i = 1'b1;
  endtask

  initial begin : watchdog
    #5_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    run(4);
    XARST_i = 1'b1;
    run(60);
    // Short press and glitch train must be rejected
    set_btn(1, 0, 0); run(15); set_btn(0, 0, 0); run(40);
    for (int i = 0; i < 14; i++) begin
      UP_i = ~UP_i;
      run($urandom_range(1, 6));
    end
    set_btn(0, 0, 0); run(60);
    // Single step
    set_btn(1, 0, 0); run(40); set_btn(0, 0, 0); run(80);
    // Auto-repeat up to saturation
    set_btn(1, 0, 0); run(800); set_btn(0, 0, 0); run(60);
    // Centre, then down to 0, then conflicting UP while DN held
    set_btn(0, 0, 1); run(40); set_btn(0, 0, 0); run(60);
    set_btn(0, 1, 0); run(900);
    set_btn(1, 1, 0); run(80);
    set_btn(0, 1, 0); run(80);
    set_btn(0, 0, 0); run(80);
    // Centre while UP is repeating
    set_btn(0, 0, 1); run(40); set_btn(0, 0, 0); run(60);
    set_btn(1, 0, 0); run(260);
    set_btn(1, 0, 1); run(40);
    set_btn(1, 0, 0); run(200);
    set_btn(0, 0, 0); run(80);
    set_btn(1, 0, 0); run(120); set_btn(0, 0, 0); run(80);
    // Reset during repeat with UP still held
    set_btn(0, 0, 1); run(40); set_btn(0, 0, 0); run(60);
    set_btn(1, 0, 0); run(450);
    pulse_reset(2);
    run(200);
    set_btn(0, 0, 0); run(80);
    // Random holds
    for (int k = 0; k < 40; k++) begin
      set_btn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 9) == 0));
      run($urandom_range(5, 400));
      if ($urandom_range(0, 19) == 0) pulse_reset($urandom_range(1, 3));
    end
    set_btn(0, 0, 0);
    run(150);
    check("pending_expected", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
